io_ports: RTL

- Parametrised memory-mapped I/O port block for the cpu. It replaces the fixed four 8-bit input and four 8-bit output ports.
- Provides NPORTS input ports, each with a two-flop synchroniser and change detection feeding a prioritised interrupt request, plus NPORTS registered output ports.
- The cpu reaches it through a simple read/write bus with registered read data.

---
 rtl/io_ports_pkg.sv | 44 ++++
 rtl/io_port_sync.sv | 34 +++
 rtl/io_ports.sv | 126 ++++++++++++
 3 files changed

// File: rtl/io_ports_pkg.sv
// Shared constants, register-map helpers and address decode for the io_ports block.
package io_ports_pkg;

    localparam int unsigned IRQ_ID_W = 3;

    typedef enum logic [2:0] {
        RK_NONE,
        RK_IN,
        RK_OUT,
        RK_PEND,
        RK_IEN
    } reg_kind_e;

    function automatic int unsigned in_base();
        return 0;
    endfunction

    function automatic int unsigned out_base(input int unsigned nports);
        return nports;
    endfunction

    function automatic int unsigned pend_addr(input int unsigned nports);
        return 2 * nports;
    endfunction

    function automatic int unsigned ien_addr(input int unsigned nports);
        return 2 * nports + 1;
    endfunction

    function automatic reg_kind_e decode(input int unsigned a, input int unsigned nports);
        reg_kind_e k;
        k = RK_NONE;
        if (a - in_base() < nports)
            k = RK_IN;
        else if (a >= out_base(nports) && a < out_base(nports) + nports)
            k = RK_OUT;
        else if (a == pend_addr(nports))
            k = RK_PEND;
        else if (a == ien_addr(nports))
            k = RK_IEN;
        return k;
    endfunction

endpackage

// File: rtl/io_port_sync.sv
// One input port: two-flop synchroniser, previous-value register and change flag.
module io_port_sync
    import io_ports_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             warm,
    output logic [WIDTH-1:0] q,
    output logic             chg
);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0 <= '0;
            sync1 <= '0;
            prev  <= '0;
        end else begin
            sync0 <= d;
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    assign q   = sync1;
    assign chg = warm && (sync1 != prev);

endmodule

// File: rtl/io_ports.sv
// Memory-mapped input/output port block with change-detect interrupts and a
// registered read path.
module io_ports
    import io_ports_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       addr,
    input  logic                    we,
    input  logic                    re,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    input  logic [NPORTS*WIDTH-1:0] in_p,
    output logic [NPORTS*WIDTH-1:0] out_p,
    output logic                    irq,
    output logic [IRQ_ID_W-1:0]     irq_id,
    input  logic                    irq_ack
);

    logic [WIDTH-1:0]        outr [NPORTS];
    logic [NPORTS*WIDTH-1:0] sync1;
    logic [NPORTS-1:0]       chg;
    logic [NPORTS-1:0]       pending;
    logic [NPORTS-1:0]       enable;
    logic [NPORTS-1:0]       active;
    logic [NPORTS-1:0]       ack_mask;
    logic [NPORTS-1:0]       wr_clr;
    logic [NPORTS-1:0]       pend_nxt;
    logic [1:0]              warm_cnt;
    logic                    warm;
    int unsigned             a;
    reg_kind_e               kind;
    logic [WIDTH-1:0]        rd_nxt;

    assign a    = 32'(addr);
    assign kind = decode(a, NPORTS);
    assign warm = &warm_cnt;

    // Power-up input values reach prev only after three edges; hold off change detection until then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            warm_cnt <= '0;
        else if (!warm)
            warm_cnt <= warm_cnt + 2'd1;
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        io_port_sync #(
            .WIDTH(WIDTH)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .d    (in_p[g*WIDTH +: WIDTH]),
            .warm (warm),
            .q    (sync1[g*WIDTH +: WIDTH]),
            .chg  (chg[g])
        );
        assign out_p[g*WIDTH +: WIDTH] = outr[g];
    end

    // Scan from the top so the lowest-numbered active port is the one left selected.
    always_comb begin
        active   = pending & enable;
        irq      = |active;
        irq_id   = '0;
        ack_mask = '0;
        for (int unsigned i = NPORTS; i > 0; i--) begin
            if (active[i-1]) begin
                irq_id        = IRQ_ID_W'(i - 1);
                ack_mask      = '0;
                ack_mask[i-1] = 1'b1;
            end
        end
    end

    // A fresh change outranks any clear aimed at the same bit in the same cycle.
    always_comb begin
        wr_clr   = (we && kind == RK_PEND) ? wdata[NPORTS-1:0] : '0;
        pend_nxt = (pending & ~(wr_clr | (irq_ack ? ack_mask : '0))) | chg;
    end

    always_comb begin
        rd_nxt = '0;
        case (kind)
            RK_IN: begin
                for (int unsigned i = 0; i < NPORTS; i++)
                    if (a == in_base() + i)
                        rd_nxt = sync1[i*WIDTH +: WIDTH];
            end
            RK_OUT: begin
                for (int unsigned i = 0; i < NPORTS; i++)
                    if (a == out_base(NPORTS) + i)
                        rd_nxt = outr[i];
            end
            RK_PEND: rd_nxt[NPORTS-1:0] = pending;
            RK_IEN:  rd_nxt[NPORTS-1:0] = enable;
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NPORTS; i++)
                outr[i] <= '0;
            pending <= '0;
            enable  <= '0;
            rdata   <= '0;
        end else begin
            if (we && kind == RK_OUT) begin
                for (int unsigned i = 0; i < NPORTS; i++)
                    if (a == out_base(NPORTS) + i)
                        outr[i] <= wdata;
            end
            if (we && kind == RK_IEN)
                enable <= wdata[NPORTS-1:0];
            pending <= pend_nxt;
            if (re)
                rdata <= rd_nxt;
        end
    end

endmodule
